// File: rtl/accum_alu_seq.sv
// Handshaked accumulator ALU: one-cycle add/sub/logic, WIDTH-cycle shift-add multiply and restoring divide/modulo.
// Optional build macro ACC_SAT_EN: overflowing add/mul saturate to all-ones, borrowing sub clamps to zero.
module accum_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] operand_p,
    output logic [WIDTH-1:0] acc_out,
    output logic             out_valid,
    output logic [1:0]       error_code,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

`ifdef ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
                           OP_MOD  = 4'h4, OP_AND  = 4'h5, OP_NAND = 4'h6, OP_NOR  = 4'h7,
                           OP_NOTP = 4'h8, OP_OR   = 4'h9, OP_XNOR = 4'hA, OP_XOR  = 4'hB,
                           OP_CLR  = 4'hC, OP_SET  = 4'hD, OP_NOP  = 4'hE, OP_LOAD = 4'hF;

    localparam logic [1:0] ERR_NONE = 2'b00, ERR_DIV0 = 2'b01, ERR_OVF = 2'b10;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
    typedef enum logic [1:0] {MC_MUL, MC_DIV, MC_MOD} mc_op_e;

    state_e           state_q, state_d;
    mc_op_e           mc_op_q, mc_op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_hi_nxt, div_lo_nxt;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_BUSY);
    assign acc_out    = acc_q;
    assign out_valid  = out_valid_q;
    assign error_code = err_q;

    assign add_full = {1'b0, acc_q} + {1'b0, operand_p};
    assign sub_full = {1'b0, acc_q} - {1'b0, operand_p};

    // Multiply: {hi,lo} starts as {0,A}; each step conditionally adds P to hi, then shifts right.
    assign mul_sum = {1'b0, hi_q} + {1'b0, p_q};
    always_comb begin
        if (lo_q[0]) {mul_hi_nxt, mul_lo_nxt} = {mul_sum, lo_q[WIDTH-1:1]};
        else         {mul_hi_nxt, mul_lo_nxt} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end

    // Restoring divide: hi holds the partial remainder, lo shifts dividend out and quotient in.
    // The remainder never reaches P, so the difference always fits in WIDTH bits.
    assign div_shift  = {hi_q, lo_q[WIDTH-1]};
    assign div_ge     = (div_shift >= {1'b0, p_q});
    assign div_diff   = div_shift[WIDTH-1:0] - p_q;
    assign div_hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_nxt = {lo_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d     = state_q;
        mc_op_d     = mc_op_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    out_valid_d = 1'b1;
                    err_d       = ERR_NONE;
                    case (op_code)
                        OP_ADD: begin
                            acc_d = add_full[WIDTH-1:0];
                            if (add_full[WIDTH]) begin
                                err_d = ERR_OVF;
                                if (SAT_EN) acc_d = ALL_ONES;
                            end
                        end
                        OP_SUB: begin
                            acc_d = sub_full[WIDTH-1:0];
                            if (sub_full[WIDTH]) begin
                                err_d = ERR_OVF;
                                if (SAT_EN) acc_d = '0;
                            end
                        end
                        OP_MUL, OP_DIV, OP_MOD: begin
                            if (op_code != OP_MUL && operand_p == '0) begin
                                err_d = ERR_DIV0;
                            end else begin
                                // Error code and acc are left alone until the iteration completes.
                                state_d     = ST_BUSY;
                                out_valid_d = 1'b0;
                                err_d       = err_q;
                                cnt_d       = '0;
                                p_d         = operand_p;
                                hi_d        = '0;
                                lo_d        = acc_q;
                                case (op_code)
                                    OP_MUL:  mc_op_d = MC_MUL;
                                    OP_DIV:  mc_op_d = MC_DIV;
                                    default: mc_op_d = MC_MOD;
                                endcase
                            end
                        end
                        OP_AND:  acc_d = acc_q & operand_p;
                        OP_NAND: acc_d = ~(acc_q & operand_p);
                        OP_NOR:  acc_d = ~(acc_q | operand_p);
                        OP_NOTP: acc_d = ~operand_p;
                        OP_OR:   acc_d = acc_q | operand_p;
                        OP_XNOR: acc_d = ~(acc_q ^ operand_p);
                        OP_XOR:  acc_d = acc_q ^ operand_p;
                        OP_CLR:  acc_d = '0;
                        OP_SET:  acc_d = ALL_ONES;
                        OP_NOP:  acc_d = acc_q;
                        default: acc_d = operand_p;
                    endcase
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (mc_op_q == MC_MUL) begin
                    hi_d = mul_hi_nxt;
                    lo_d = mul_lo_nxt;
                end else begin
                    hi_d = div_hi_nxt;
                    lo_d = div_lo_nxt;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    err_d       = ERR_NONE;
                    case (mc_op_q)
                        MC_MUL: begin
                            acc_d = mul_lo_nxt;
                            if (mul_hi_nxt != '0) begin
                                err_d = ERR_OVF;
                                if (SAT_EN) acc_d = ALL_ONES;
                            end
                        end
                        MC_DIV:  acc_d = div_lo_nxt;
                        default: acc_d = div_hi_nxt;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mc_op_q     <= MC_MUL;
            acc_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            err_q       <= ERR_NONE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_op_q     <= mc_op_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_accum_alu_seq.sv
// Directed bench for accum_alu_seq (WIDTH=32): each task drives one scenario and checks against hand-computed values.
module tb_accum_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op_code = 4'h0;
    logic [W-1:0] operand_p = '0;
    logic [W-1:0] acc_out;
    logic         out_valid;
    logic [1:0]   error_code;
    logic         busy;

    int tests = 0;
    int fails = 0;

    accum_alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_code    (op_code),
        .operand_p  (operand_p),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .error_code (error_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Present one op at the negedge, let it be sampled, and return 1 time unit after that edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] p);
        @(negedge clk);
        in_valid  = 1'b1;
        op_code   = op;
        operand_p = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue a multi-cycle op; report edges from accept until out_valid and whether busy/in_ready misbehaved.
    task automatic run_multi(input logic [3:0] op, input logic [W-1:0] p, input logic poke,
                             output int lat, output logic busy_bad);
        issue(op, p);
        busy_bad = (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0);
        lat = -1;
        if (poke) begin
            in_valid  = 1'b1;
            op_code   = 4'hF;
            operand_p = 32'h0000_DEAD;
        end
        for (int k = 1; k <= W + 8 && lat < 0; k++) begin
            if (k == W) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) lat = k;
            else if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        tests++; if (acc_out !== '0)      begin fails++; $display("FAIL reset_acc got %h exp 0", acc_out); end
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_ov got %b exp 0", out_valid); end
        tests++; if (error_code !== 2'b00) begin fails++; $display("FAIL reset_err got %b exp 00", error_code); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_add;
        issue(4'hF, 32'd5);
        tests++; if (acc_out !== 32'd5 || out_valid !== 1'b1 || in_ready !== 1'b1)
            begin fails++; $display("FAIL load acc %h ov %b rdy %b exp 5 1 1", acc_out, out_valid, in_ready); end
        issue(4'h0, 32'd7);
        tests++; if (acc_out !== 32'd12 || out_valid !== 1'b1 || error_code !== 2'b00)
            begin fails++; $display("FAIL add acc %h ov %b err %b exp 0000000c 1 00", acc_out, out_valid, error_code); end
        tests++; if (in_ready !== 1'b1 || busy !== 1'b0)
            begin fails++; $display("FAIL add_ready rdy %b busy %b exp 1 0", in_ready, busy); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0 || acc_out !== 32'd12)
            begin fails++; $display("FAIL add_pulse ov %b acc %h exp 0 0000000c", out_valid, acc_out); end
    endtask

    task automatic test_add_sub_overflow;
        logic [W-1:0] exp_add, exp_sub;
`ifdef ACC_SAT_EN
        exp_add = 32'hFFFF_FFFF;
        exp_sub = 32'h0000_0000;
`else
        exp_add = 32'h0000_0000;
        exp_sub = 32'hFFFF_FFFE;
`endif
        issue(4'hF, 32'hFFFF_FFFF);
        issue(4'h0, 32'd1);
        tests++; if (acc_out !== exp_add || error_code !== 2'b10)
            begin fails++; $display("FAIL add_ovf acc %h err %b exp %h 10", acc_out, error_code, exp_add); end
        issue(4'hF, 32'd10);
        issue(4'h1, 32'd3);
        tests++; if (acc_out !== 32'd7 || error_code !== 2'b00)
            begin fails++; $display("FAIL sub acc %h err %b exp 00000007 00", acc_out, error_code); end
        issue(4'h1, 32'd9);
        tests++; if (acc_out !== exp_sub || error_code !== 2'b10)
            begin fails++; $display("FAIL sub_borrow acc %h err %b exp %h 10", acc_out, error_code, exp_sub); end
    endtask

    task automatic test_logic;
        logic [3:0]   ops  [10] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        logic [W-1:0] exps [10] = '{32'hF000_1200, 32'h0FFF_EDFF, 32'h000F_00CB, 32'h00FF_00FF,
                                    32'hFFF0_FF34, 32'hF00F_12CB, 32'h0FF0_ED34, 32'h0000_0000,
                                    32'hFFFF_FFFF, 32'hF0F0_1234};
        for (int i = 0; i < 10; i++) begin
            issue(4'hF, 32'hF0F0_1234);
            issue(ops[i], 32'hFF00_FF00);
            tests++; if (acc_out !== exps[i] || error_code !== 2'b00 || out_valid !== 1'b1)
                begin fails++; $display("FAIL logic_op%h acc %h err %b ov %b exp %h 00 1",
                                        ops[i], acc_out, error_code, out_valid, exps[i]); end
        end
    endtask

    task automatic test_multiply;
        int lat; logic bad; logic [W-1:0] exp_ovf;
        issue(4'hF, 32'd6);
        run_multi(4'h2, 32'd7, 1'b1, lat, bad);
        tests++; if (lat !== W) begin fails++; $display("FAIL mul_latency got %0d exp %0d", lat, W); end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL mul_busy_window got %b exp 0", bad); end
        tests++; if (acc_out !== 32'd42 || error_code !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL mul acc %h err %b busy %b rdy %b exp 0000002a 00 0 1",
                                    acc_out, error_code, busy, in_ready); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0 || acc_out !== 32'd42)
            begin fails++; $display("FAIL mul_pulse ov %b acc %h exp 0 0000002a", out_valid, acc_out); end
        issue(4'hF, 32'h0001_2345);
        run_multi(4'h2, 32'h100, 1'b0, lat, bad);
        tests++; if (acc_out !== 32'h0123_4500 || error_code !== 2'b00)
            begin fails++; $display("FAIL mul2 acc %h err %b exp 01234500 00", acc_out, error_code); end
`ifdef ACC_SAT_EN
        exp_ovf = 32'hFFFF_FFFF;
`else
        exp_ovf = 32'h0000_0001;
`endif
        issue(4'hF, 32'hFFFF_FFFF);
        run_multi(4'h2, 32'hFFFF_FFFF, 1'b0, lat, bad);
        tests++; if (acc_out !== exp_ovf || error_code !== 2'b10)
            begin fails++; $display("FAIL mul_ovf acc %h err %b exp %h 10", acc_out, error_code, exp_ovf); end
    endtask

    task automatic test_divmod;
        int lat; logic bad;
        issue(4'hF, 32'd100);
        run_multi(4'h3, 32'd7, 1'b0, lat, bad);
        tests++; if (lat !== W || bad !== 1'b0)
            begin fails++; $display("FAIL div_timing lat %0d bad %b exp %0d 0", lat, bad, W); end
        tests++; if (acc_out !== 32'd14 || error_code !== 2'b00)
            begin fails++; $display("FAIL div acc %h err %b exp 0000000e 00", acc_out, error_code); end
        run_multi(4'h4, 32'd5, 1'b0, lat, bad);
        tests++; if (acc_out !== 32'd4 || error_code !== 2'b00)
            begin fails++; $display("FAIL mod acc %h err %b exp 00000004 00", acc_out, error_code); end
        issue(4'hF, 32'hDEAD_BEEF);
        run_multi(4'h4, 32'h100, 1'b0, lat, bad);
        tests++; if (acc_out !== 32'h0000_00EF)
            begin fails++; $display("FAIL mod2 acc %h exp 000000ef", acc_out); end
        issue(4'hF, 32'hFFFF_FFFF);
        run_multi(4'h3, 32'h10, 1'b0, lat, bad);
        tests++; if (acc_out !== 32'h0FFF_FFFF)
            begin fails++; $display("FAIL div2 acc %h exp 0fffffff", acc_out); end
    endtask

    task automatic test_div_zero;
        issue(4'hF, 32'd9);
        issue(4'h3, 32'd0);
        tests++; if (acc_out !== 32'd9 || error_code !== 2'b01 || out_valid !== 1'b1 || busy !== 1'b0)
            begin fails++; $display("FAIL div0 acc %h err %b ov %b busy %b exp 00000009 01 1 0",
                                    acc_out, error_code, out_valid, busy); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || error_code !== 2'b01)
            begin fails++; $display("FAIL div0_after busy %b ov %b err %b exp 0 0 01", busy, out_valid, error_code); end
        issue(4'h4, 32'd0);
        tests++; if (acc_out !== 32'd9 || error_code !== 2'b01 || busy !== 1'b0)
            begin fails++; $display("FAIL mod0 acc %h err %b busy %b exp 00000009 01 0", acc_out, error_code, busy); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   ops  [4] = '{4'hF, 4'h0, 4'h1, 4'hB};
        logic [W-1:0] ps   [4] = '{32'd3, 32'd4, 32'd2, 32'hF};
        logic [W-1:0] exps [4] = '{32'd3, 32'd7, 32'd5, 32'hA};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            op_code   = ops[i];
            operand_p = ps[i];
            @(posedge clk); #1;
            tests++; if (acc_out !== exps[i] || out_valid !== 1'b1 || in_ready !== 1'b1)
                begin fails++; $display("FAIL b2b_%0d acc %h ov %b rdy %b exp %h 1 1",
                                        i, acc_out, out_valid, in_ready, exps[i]); end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        int pulses = 0;
        issue(4'hF, 32'd6);
        issue(4'h2, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (acc_out !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            begin fails++; $display("FAIL rst_mid acc %h busy %b rdy %b ov %b exp 0 0 1 0",
                                    acc_out, busy, in_ready, out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 8; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) pulses++;
        end
        tests++; if (pulses != 0 || acc_out !== '0)
            begin fails++; $display("FAIL rst_abort pulses %0d acc %h exp 0 0", pulses, acc_out); end
        issue(4'hF, 32'd3);
        tests++; if (acc_out !== 32'd3 || out_valid !== 1'b1)
            begin fails++; $display("FAIL rst_recover acc %h ov %b exp 00000003 1", acc_out, out_valid); end
    endtask

    initial begin
        test_reset;
        test_load_add;
        test_add_sub_overflow;
        test_logic;
        test_multiply;
        test_divmod;
        test_div_zero;
        test_back_to_back;
        test_reset_mid_op;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/accum_alu_seq.md
Name: accum_alu_seq

Overview:
- Parametrised, handshaked successor to the accumulator ALU.
- A WIDTH-bit accumulator register is the left operand of every op; operand_p is the right operand. The result is written back to the accumulator.
- Add, sub and logic ops complete in one cycle. Multiply, divide and modulo run on iterative shift-add / restoring datapaths taking WIDTH cycles each.
- Sits between the operand/opcode source and the result consumer; in_ready provides back-pressure.

Parameters:
- WIDTH, 32, datapath and accumulator width in bits (valid range 4..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  op_code/operand_p valid
- in_ready  output  1  block can accept an op
- op_code  input  4  operation select
- operand_p  input  WIDTH  right operand
- acc_out  output  WIDTH  accumulator value (registered)
- out_valid  output  1  one-cycle pulse: acc_out/error_code updated by a completed op
- error_code  output  2  00 none, 01 divide-by-zero, 10 overflow
- busy  output  1  multi-cycle op in progress

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset values: acc_out=0, out_valid=0, error_code=00, busy=0, in_ready=1, FSM=IDLE. rst_n deasserting mid-operation aborts the op; no out_valid is produced for it.
- Accept: an op is accepted on a clk edge where in_valid && in_ready. in_ready = (state==IDLE), combinational from state.
- Opcodes, with A=acc, P=operand_p, all unsigned:
  - 0000 A+P; 0001 A-P; 0010 A*P; 0011 A/P; 0100 A%P
  - 0101 A&P; 0110 ~(A&P); 0111 ~(A|P); 1000 ~P; 1001 A|P; 1010 ~(A^P); 1011 A^P
  - 1100 clear to 0; 1101 preset to all-ones; 1110 no-op (A held); 1111 load P
- Single-cycle ops: acc is updated on the accept edge. out_valid is high the following cycle only. The FSM stays in IDLE, so back-to-back accepts are allowed every cycle.
- Multi-cycle ops (0010/0011/0100): the accept edge latches A and P and moves the FSM IDLE->BUSY with the iteration counter at 0. Each cycle processes one bit. After exactly WIDTH cycles in BUSY, acc is written and the FSM returns to IDLE. out_valid pulses the cycle after the write.
- Latency, accept to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for multi-cycle ops.
- busy=1 and in_ready=0 throughout BUSY. in_valid is ignored while busy.
- Multiply: low WIDTH bits of the 2*WIDTH product are written. Overflow (10) is flagged if the upper half is nonzero.
- Add: overflow (10) on carry-out. Sub: overflow (10) on borrow (P>A). Result wraps modulo 2^WIDTH.
- Divide/modulo by zero:
  - No iteration is performed; the op completes as single-cycle.
  - acc is held and error_code=01.
- Logic ops, 1100, 1101, 1110 and 1111 always report error_code 00.
- error_code is updated together with every completion. It holds its value until the next completion.
- acc_out changes only at completion edges or on reset.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: on overflow, add and mul write all-ones and sub writes 0; error_code still reports 10.
- Undefined: results wrap as described above.
- Divide-by-zero behaviour is identical in both builds.

Test Plan:
- Reset, load, add: reset, then 1111 P=5, then 0000 P=7 -> acc_out=12, error 00, out_valid one cycle after each accept, in_ready held 1.
- Add overflow: acc=0xFFFFFFFF, 0000 P=1 -> wrap build acc=0, error 10; ACC_SAT_EN build acc=0xFFFFFFFF, error 10.
- Multiply timing: acc=6, 0010 P=7 -> busy/in_ready=0 for 32 cycles, acc_out=42 with out_valid at accept+33; in_valid asserted during BUSY is ignored.
- Divide and modulo: acc=100, 0011 P=7 -> acc=14; then 0100 P=5 -> acc=4; error 00 both.
- Divide by zero: acc=9, 0011 P=0 -> acc stays 9, error 01, out_valid at accept+1, busy never asserted.
- Reset mid-op: assert rst_n=0 at cycle 10 of a multiply -> acc_out=0, busy=0, in_ready=1 immediately, no out_valid for the aborted op.
